// File: rtl/plab4_net_router_input_buf_sep_pkg.sv
// Shared message definitions for the plab4 network router stages:
// field widths, message layout helpers and field extraction macros.
// Message layout (MSB to LSB): {dest, src, opaque, payload}.

`ifndef PLAB4_NET_MSGS_MACROS
`define PLAB4_NET_MSGS_MACROS
// Destination field: the top dest_nbits of a message of msg_nbits bits.
`define PLAB4_NET_MSG_DEST(msg, msg_nbits, dest_nbits) msg[(msg_nbits)-1 -: (dest_nbits)]
// Source field: immediately below the destination field.
`define PLAB4_NET_MSG_SRC(msg, msg_nbits, dest_nbits) msg[(msg_nbits)-(dest_nbits)-1 -: (dest_nbits)]
`endif

package plab4_net_router_input_buf_sep_pkg;

  localparam int unsigned c_def_num_routers   = 32'd8;
  localparam int unsigned c_def_opaque_nbits  = 32'd8;
  localparam int unsigned c_def_payload_nbits = 32'd32;
  localparam int unsigned c_def_num_entries   = 32'd4;

  // Total message width for a given dest/opaque/payload sizing.
  function automatic int unsigned msg_nbits(input int unsigned dest_nbits,
                                            input int unsigned opaque_nbits,
                                            input int unsigned payload_nbits);
    return 32'd2 * dest_nbits + opaque_nbits + payload_nbits;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/plab4_net_router_input_buf_sep_domain_queue.sv
// plab4_net_domain_queue: one circular-buffer queue of network messages
// with head/tail pointers, an occupancy count and a free-entry output.
// Optional feature macro: PLAB4_NET_INBUF_BYPASS_EN forwards an incoming
// message straight to the head outputs while the queue is empty; a message
// consumed that way is never written into storage.

module plab4_net_domain_queue
  import plab4_net_router_input_buf_sep_pkg::*;
#(
  parameter int unsigned p_msg_nbits   = 32'd46,
  parameter int unsigned p_num_entries = c_def_num_entries
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_msg_nbits-1:0]            enq_msg_i,
  input  logic                              enq_val_i,
  output logic                              enq_rdy_o,
  output logic [p_msg_nbits-1:0]            deq_msg_o,
  output logic                              deq_val_o,
  input  logic                              deq_rdy_i,
  output logic [$clog2(p_num_entries):0]    num_free_o
);

  localparam int unsigned c_ptr_nbits = $clog2(p_num_entries);
  localparam int unsigned c_cnt_nbits = c_ptr_nbits + 32'd1;

  localparam logic [c_ptr_nbits-1:0] c_ptr_zero = c_ptr_nbits'(0);
  localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] c_cnt_zero = c_cnt_nbits'(0);
  localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_num_entries);

  if (!is_pow2(p_num_entries) || (p_num_entries < 32'd2)) begin : g_bad_depth
    $error("plab4_net_domain_queue: p_num_entries must be a power of two >= 2");
  end

  logic [p_msg_nbits-1:0] mem_q [p_num_entries];
  logic [c_ptr_nbits-1:0] head_q, head_d;
  logic [c_ptr_nbits-1:0] tail_q, tail_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;
  logic                   full_s;
  logic                   empty_s;
  logic                   wr_en_s;
  logic                   rd_en_s;

  // Head presentation, enqueue/dequeue qualification and next-state pointers.
  always_comb begin
    full_s     = (count_q == c_cnt_full);
    empty_s    = (count_q == c_cnt_zero);
    enq_rdy_o  = !full_s;
    num_free_o = c_cnt_full - count_q;
`ifdef PLAB4_NET_INBUF_BYPASS_EN
    // While empty the incoming message is the head; if it is taken in the
    // same cycle it never lands in storage.
    deq_val_o  = !empty_s || enq_val_i;
    deq_msg_o  = empty_s ? enq_msg_i : mem_q[head_q];
    wr_en_s    = enq_val_i && !full_s && !(empty_s && deq_rdy_i);
    rd_en_s    = !empty_s && deq_rdy_i;
`else
    deq_val_o  = !empty_s;
    deq_msg_o  = mem_q[head_q];
    wr_en_s    = enq_val_i && !full_s;
    rd_en_s    = !empty_s && deq_rdy_i;
`endif

    if (rd_en_s) begin
      head_d = head_q + c_ptr_one;
    end else begin
      head_d = head_q;
    end

    if (wr_en_s) begin
      tail_d = tail_q + c_ptr_one;
    end else begin
      tail_d = tail_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset empties the queue immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= c_ptr_zero;
      tail_q  <= c_ptr_zero;
      count_q <= c_cnt_zero;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Message storage; contents are meaningful only between head and tail.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[tail_q] <= enq_msg_i;
    end
  end

endmodule

// File: rtl/plab4_net_router_input_buf_sep.sv
// plab4_net_router_input_buf_sep: per-port input buffer that steers each
// incoming message into one of two independent domain queues by its domain
// bit and presents each queue's head, destination and valid flag.
// Optional feature macro: PLAB4_NET_INBUF_BYPASS_EN (handled in the queues).

module plab4_net_router_input_buf_sep
  import plab4_net_router_input_buf_sep_pkg::*;
#(
  parameter int unsigned p_router_id     = 32'd0,
  parameter int unsigned p_num_routers   = c_def_num_routers,
  parameter int unsigned p_opaque_nbits  = c_def_opaque_nbits,
  parameter int unsigned p_payload_nbits = c_def_payload_nbits,
  parameter int unsigned p_num_entries   = c_def_num_entries,
  localparam int unsigned c_dest_nbits   = $clog2(p_num_routers),
  localparam int unsigned c_msg_nbits    = msg_nbits(c_dest_nbits, p_opaque_nbits, p_payload_nbits)
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [c_msg_nbits-1:0]         in_msg,
  input  logic                           in_domain,
  input  logic                           in_val,
  output logic                           in_rdy,
  output logic [c_msg_nbits-1:0]         out_msg_d1,
  output logic [c_msg_nbits-1:0]         out_msg_d2,
  output logic [c_dest_nbits-1:0]        dest_d1,
  output logic [c_dest_nbits-1:0]        dest_d2,
  output logic                           out_val_d1,
  output logic                           out_val_d2,
  input  logic                           out_rdy_d1,
  input  logic                           out_rdy_d2,
  output logic [$clog2(p_num_entries):0] num_free_d1,
  output logic [$clog2(p_num_entries):0] num_free_d2
);

  if (p_router_id >= p_num_routers) begin : g_bad_router_id
    $error("plab4_net_router_input_buf_sep: p_router_id out of range");
  end

  logic enq_val_d1_s;
  logic enq_val_d2_s;
  logic enq_rdy_d1_s;
  logic enq_rdy_d2_s;

  // Steer the upstream handshake to the queue selected by the domain bit.
  always_comb begin
    enq_val_d1_s = in_val && !in_domain;
    enq_val_d2_s = in_val && in_domain;
    if (in_domain) begin
      in_rdy = enq_rdy_d2_s;
    end else begin
      in_rdy = enq_rdy_d1_s;
    end
  end

  // Destination field of each head message for the arbitration stage.
  always_comb begin
    dest_d1 = `PLAB4_NET_MSG_DEST(out_msg_d1, c_msg_nbits, c_dest_nbits);
    dest_d2 = `PLAB4_NET_MSG_DEST(out_msg_d2, c_msg_nbits, c_dest_nbits);
  end

  plab4_net_domain_queue #(
    .p_msg_nbits   (c_msg_nbits),
    .p_num_entries (p_num_entries)
  ) u_queue_d1 (
    .clk        (clk),
    .reset      (reset),
    .enq_msg_i  (in_msg),
    .enq_val_i  (enq_val_d1_s),
    .enq_rdy_o  (enq_rdy_d1_s),
    .deq_msg_o  (out_msg_d1),
    .deq_val_o  (out_val_d1),
    .deq_rdy_i  (out_rdy_d1),
    .num_free_o (num_free_d1)
  );

  plab4_net_domain_queue #(
    .p_msg_nbits   (c_msg_nbits),
    .p_num_entries (p_num_entries)
  ) u_queue_d2 (
    .clk        (clk),
    .reset      (reset),
    .enq_msg_i  (in_msg),
    .enq_val_i  (enq_val_d2_s),
    .enq_rdy_o  (enq_rdy_d2_s),
    .deq_msg_o  (out_msg_d2),
    .deq_val_o  (out_val_d2),
    .deq_rdy_i  (out_rdy_d2),
    .num_free_o (num_free_d2)
  );

endmodule

// File: tb/tb_plab4_net_router_input_buf_sep.sv
// Directed, table-driven bench for plab4_net_router_input_buf_sep with the
// default sizing (8 routers, 46-bit messages, 4 entries per domain queue).

module tb_plab4_net_router_input_buf_sep;

`ifdef PLAB4_NET_INBUF_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  localparam int unsigned c_msg_nbits = 46;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [c_msg_nbits-1:0] in_msg;
  logic                   in_domain;
  logic                   in_val;
  logic                   in_rdy;
  logic [c_msg_nbits-1:0] out_msg_d1;
  logic [c_msg_nbits-1:0] out_msg_d2;
  logic [2:0]             dest_d1;
  logic [2:0]             dest_d2;
  logic                   out_val_d1;
  logic                   out_val_d2;
  logic                   out_rdy_d1;
  logic                   out_rdy_d2;
  logic [2:0]             num_free_d1;
  logic [2:0]             num_free_d2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  plab4_net_router_input_buf_sep dut (
    .clk         (clk),
    .reset       (reset),
    .in_msg      (in_msg),
    .in_domain   (in_domain),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .out_msg_d1  (out_msg_d1),
    .out_msg_d2  (out_msg_d2),
    .dest_d1     (dest_d1),
    .dest_d2     (dest_d2),
    .out_val_d1  (out_val_d1),
    .out_val_d2  (out_val_d2),
    .out_rdy_d1  (out_rdy_d1),
    .out_rdy_d2  (out_rdy_d2),
    .num_free_d1 (num_free_d1),
    .num_free_d2 (num_free_d2)
  );

  typedef struct {
    logic       dom;
    logic       val;
    logic [2:0] dst;
    logic       r1;
    logic       r2;
    logic       e_rdy;
    logic       e_v1;
    logic       e_v2;
    logic [2:0] e_d1;
    logic [2:0] e_d2;
    logic [2:0] e_f1;
    logic [2:0] e_f2;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mv(input logic dom, input logic val, input logic [2:0] dst,
                              input logic r1, input logic r2, input logic e_rdy,
                              input logic e_v1, input logic e_v2,
                              input logic [2:0] e_d1, input logic [2:0] e_d2,
                              input logic [2:0] e_f1, input logic [2:0] e_f2);
    vec_t v;
    v.dom = dom; v.val = val; v.dst = dst; v.r1 = r1; v.r2 = r2;
    v.e_rdy = e_rdy; v.e_v1 = e_v1; v.e_v2 = e_v2;
    v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_f1 = e_f1; v.e_f2 = e_f2;
    return v;
  endfunction

  // Message {dest, src=0, opaque=tag, payload={A5C3E1, tag}}.
  function automatic logic [c_msg_nbits-1:0] mk(input logic [2:0] dest, input logic [7:0] tag);
    return {dest, 3'b000, tag, 24'hA5C3E1, tag};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_in;
    logic [7:0] seq_out;
    int         model_cnt;

    reset = 1'b1; in_msg = '0; in_domain = 1'b0; in_val = 1'b0;
    out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;

    //           dom  val dst r1 r2  rdy  v1    v2    d1 d2 f1 f2
    tbl[0]  = mv(1'b0,1'b1,3'd3,1'b0,1'b0, 1'b1,c_byp,1'b0, 3'd3,3'd0,3'd4,3'd4);
    tbl[1]  = mv(1'b0,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b1, 1'b0, 3'd3,3'd0,3'd3,3'd4);
    tbl[2]  = mv(1'b1,1'b1,3'd4,1'b0,1'b0, 1'b1,1'b1, c_byp,3'd3,3'd4,3'd3,3'd4);
    tbl[3]  = mv(1'b1,1'b1,3'd5,1'b0,1'b0, 1'b1,1'b1, 1'b1, 3'd3,3'd4,3'd3,3'd3);
    tbl[4]  = mv(1'b1,1'b1,3'd6,1'b0,1'b0, 1'b1,1'b1, 1'b1, 3'd3,3'd4,3'd3,3'd2);
    tbl[5]  = mv(1'b1,1'b1,3'd7,1'b0,1'b0, 1'b1,1'b1, 1'b1, 3'd3,3'd4,3'd3,3'd1);
    tbl[6]  = mv(1'b1,1'b1,3'd0,1'b0,1'b0, 1'b0,1'b1, 1'b1, 3'd3,3'd4,3'd3,3'd0);
    tbl[7]  = mv(1'b0,1'b1,3'd1,1'b0,1'b0, 1'b1,1'b1, 1'b1, 3'd3,3'd4,3'd3,3'd0);
    tbl[8]  = mv(1'b1,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b1, 1'b1, 3'd3,3'd4,3'd2,3'd0);
    tbl[9]  = mv(1'b0,1'b0,3'd0,1'b1,1'b1, 1'b1,1'b1, 1'b1, 3'd3,3'd4,3'd2,3'd0);
    tbl[10] = mv(1'b1,1'b1,3'd2,1'b0,1'b1, 1'b1,1'b1, 1'b1, 3'd1,3'd5,3'd3,3'd1);
    tbl[11] = mv(1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b1, 1'b1, 3'd1,3'd6,3'd3,3'd1);

    // Reset, release, one idle cycle.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("reset in_rdy", 64'(in_rdy), 64'(1'b1));
    check("reset out_val_d1", 64'(out_val_d1), 64'(1'b0));
    check("reset out_val_d2", 64'(out_val_d2), 64'(1'b0));
    check("reset num_free_d1", 64'(num_free_d1), 64'(3'd4));
    check("reset num_free_d2", 64'(num_free_d2), 64'(3'd4));

    // Table vectors: inputs driven after the falling edge, outputs checked
    // before the next rising edge commits them.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_domain = tbl[i].dom; in_val = tbl[i].val; in_msg = mk(tbl[i].dst, 8'(i));
      out_rdy_d1 = tbl[i].r1; out_rdy_d2 = tbl[i].r2;
      #1;
      check($sformatf("vec%0d in_rdy", i), 64'(in_rdy), 64'(tbl[i].e_rdy));
      check($sformatf("vec%0d out_val_d1", i), 64'(out_val_d1), 64'(tbl[i].e_v1));
      check($sformatf("vec%0d out_val_d2", i), 64'(out_val_d2), 64'(tbl[i].e_v2));
      if (tbl[i].e_v1) check($sformatf("vec%0d dest_d1", i), 64'(dest_d1), 64'(tbl[i].e_d1));
      if (tbl[i].e_v2) check($sformatf("vec%0d dest_d2", i), 64'(dest_d2), 64'(tbl[i].e_d2));
      check($sformatf("vec%0d num_free_d1", i), 64'(num_free_d1), 64'(tbl[i].e_f1));
      check($sformatf("vec%0d num_free_d2", i), 64'(num_free_d2), 64'(tbl[i].e_f2));
    end

    // Drain both queues (d1 holds 1, d2 holds 3), then sit empty with ready high.
    @(negedge clk);
    in_val = 1'b0; out_rdy_d1 = 1'b1; out_rdy_d2 = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("drain out_val_d1", 64'(out_val_d1), 64'(1'b0));
    check("drain out_val_d2", 64'(out_val_d2), 64'(1'b0));
    check("drain num_free_d1", 64'(num_free_d1), 64'(3'd4));
    check("drain num_free_d2", 64'(num_free_d2), 64'(3'd4));

    // Fill d1 with seq 0..3, then stream with dequeue and offer every cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_domain = 1'b0; in_val = 1'b1; out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;
      in_msg = mk(3'(k), 8'(k));
    end
    seq_in = 8'd4; seq_out = 8'd0; model_cnt = 4;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_domain = 1'b0; in_val = 1'b1; out_rdy_d1 = 1'b1;
      in_msg = mk(seq_in[2:0], seq_in);
      #1;
      check($sformatf("stream%0d in_rdy", c), 64'(in_rdy), 64'(model_cnt != 4));
      check($sformatf("stream%0d out_val_d1", c), 64'(out_val_d1), 64'(1'b1));
      check($sformatf("stream%0d dest_d1", c), 64'(dest_d1), 64'(seq_out[2:0]));
      check($sformatf("stream%0d out_msg_d1", c), 64'(out_msg_d1), 64'(mk(seq_out[2:0], seq_out)));
      check($sformatf("stream%0d num_free_d1", c), 64'(num_free_d1), 64'(4 - model_cnt));
      if (model_cnt != 4) begin
        seq_in = seq_in + 8'd1;
        model_cnt = model_cnt + 1;
      end
      seq_out = seq_out + 8'd1;
      model_cnt = model_cnt - 1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_val = 1'b0; out_rdy_d1 = 1'b1;
      #1;
      check($sformatf("tail%0d out_val_d1", c), 64'(out_val_d1), 64'(1'b1));
      check($sformatf("tail%0d out_msg_d1", c), 64'(out_msg_d1), 64'(mk(seq_out[2:0], seq_out)));
      seq_out = seq_out + 8'd1;
    end
    @(negedge clk); #1;
    check("stream end seq", 64'(seq_out), 64'(8'd15));
    check("stream end out_val_d1", 64'(out_val_d1), 64'(1'b0));
    check("stream end num_free_d1", 64'(num_free_d1), 64'(3'd4));

    // Three messages into d2, then a reset pulse between clock edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_domain = 1'b1; in_val = 1'b1; out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;
      in_msg = mk(3'(k + 1), 8'h40 + 8'(k));
    end
    @(negedge clk);
    in_val = 1'b0;
    #1;
    check("prereset out_val_d2", 64'(out_val_d2), 64'(1'b1));
    check("prereset num_free_d2", 64'(num_free_d2), 64'(3'd1));
    #1 reset = 1'b1;
    #1;
    check("midreset out_val_d2", 64'(out_val_d2), 64'(1'b0));
    check("midreset num_free_d2", 64'(num_free_d2), 64'(3'd4));
    check("midreset in_rdy", 64'(in_rdy), 64'(1'b1));
    #1 reset = 1'b0;
    @(negedge clk);
    in_domain = 1'b1; in_val = 1'b1; in_msg = mk(3'd6, 8'h77);
    @(negedge clk);
    in_val = 1'b0;
    #1;
    check("postreset out_val_d2", 64'(out_val_d2), 64'(1'b1));
    check("postreset dest_d2", 64'(dest_d2), 64'(3'd6));
    check("postreset out_msg_d2", 64'(out_msg_d2), 64'(mk(3'd6, 8'h77)));
    check("postreset num_free_d2", 64'(num_free_d2), 64'(3'd3));
    out_rdy_d2 = 1'b1;
    @(negedge clk); #1;
    check("postreset drained", 64'(out_val_d2), 64'(1'b0));

    // Empty d1 offered a message with ready high: latency depends on bypass.
    @(negedge clk);
    in_domain = 1'b0; in_val = 1'b1; out_rdy_d1 = 1'b1; in_msg = mk(3'd5, 8'h99);
    #1;
    check("bypass cycle out_val_d1", 64'(out_val_d1), 64'(c_byp));
    if (out_val_d1) check("bypass cycle dest_d1", 64'(dest_d1), 64'(3'd5));
    @(negedge clk);
    in_val = 1'b0; out_rdy_d1 = 1'b0;
    #1;
    check("bypass next out_val_d1", 64'(out_val_d1), 64'(!c_byp));
    check("bypass next num_free_d1", 64'(num_free_d1), 64'(c_byp ? 3'd4 : 3'd3));
    if (out_val_d1) check("bypass next dest_d1", 64'(dest_d1), 64'(3'd5));
    out_rdy_d1 = 1'b1;
    @(negedge clk); #1;
    check("final out_val_d1", 64'(out_val_d1), 64'(1'b0));
    check("final num_free_d1", 64'(num_free_d1), 64'(3'd4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_input_buf_sep.md
# plab4_net_router_input_buf_sep

Per-port, domain-separated input buffer for the router. It accepts network messages from the upstream channel and steers each into one of two private queues by its domain bit. It presents each queue's head message, destination and valid flag to the separated input-control arbitration stage, which returns per-domain ready. The two domains share no storage and no backpressure path, so a full or stalled domain never blocks the other.

## Interface
Parameters:
- p_router_id, 0, id of the owning router (passed through for field checks only)
- p_num_routers, 8, routers in network; c_dest_nbits = $clog2(p_num_routers)
- p_opaque_nbits, 8, opaque field width
- p_payload_nbits, 32, payload width
- p_num_entries, 4, entries per domain queue; power of two, ≥2
- c_msg_nbits, derived, 2*c_dest_nbits + p_opaque_nbits + p_payload_nbits; layout {dest, src, opaque, payload}, dest in MSBs

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_msg  in  c_msg_nbits  incoming message
- in_domain  in  1  0 = domain1, 1 = domain2
- in_val  in  1  incoming valid
- in_rdy  out  1  incoming ready
- out_msg_d1 / out_msg_d2  out  c_msg_nbits  head message of each queue
- dest_d1 / dest_d2  out  c_dest_nbits  dest field of each head message
- out_val_d1 / out_val_d2  out  1  queue non-empty
- out_rdy_d1 / out_rdy_d2  in  1  dequeue ready from the input-control arbitration stage
- num_free_d1 / num_free_d2  out  $clog2(p_num_entries)+1  free entries per queue

## Operation
- Enqueue fires when in_val && in_rdy. Target queue is d1 if in_domain==0, else d2.
- in_rdy is combinational: in_domain ? !full_d2 : !full_d1. It depends only on the target queue.
- Dequeue on domain k fires when out_val_dk && out_rdy_dk. The two domains dequeue independently, and both may dequeue in the same cycle.
- Each queue is a circular buffer with head pointer, tail pointer and count.
  - Pointers are $clog2(p_num_entries) bits and wrap modulo p_num_entries.
  - count ranges over 0..p_num_entries.
- Enqueue and dequeue on the same queue in the same cycle:
  - both pointers advance and count is unchanged;
  - when the queue is full, enqueue is still refused (no pipe-through).
- dest_dk = out_msg_dk[c_msg_nbits-1 -: c_dest_nbits].
- When a queue is empty, out_msg_dk and dest_dk are don't-care and out_val_dk = 0.
- num_free_dk = p_num_entries − count_dk.

## Timing
- Reset values:
  - pointers and counts = 0
  - out_val_d1 = out_val_d2 = 0
  - num_free_d1 = num_free_d2 = p_num_entries
  - in_rdy = 1
- Reset asserted mid-operation discards all queued messages asynchronously. out_val drops in the same cycle, with no wait for a clock edge.
- Baseline latency: a message enqueued at edge N is visible as out_val_dk = 1 after edge N, i.e. in cycle N+1.
- Throughput: one enqueue per cycle, plus one dequeue per domain per cycle.
- Full condition: in_rdy = 0 for that domain only. The other domain still accepts.
- Empty queue with out_rdy high: no dequeue occurs, and pointers do not move.

## Configuration
- PLAB4_NET_INBUF_BYPASS_EN defined:
  - when the target queue is empty and in_val is high, the message is forwarded combinationally to out_msg_dk and dest_dk with out_val_dk = 1 (0-cycle latency);
  - if out_rdy_dk is also high, the message is consumed and not written, so count stays 0.
- Undefined: no combinational path from in_msg to out_msg; latency is exactly 1 cycle.

## Structure
- Shared package (plab4-net-msgs) holds:
  - c_dest_nbits and the message field width constants;
  - the message layout and dest/src field extraction macros, also used by the input-control and route-compute stages.
- One sub-module, plab4_net_domain_queue: a single circular buffer with count, bypass option and num_free output. It is instantiated twice, once per domain.
- Top level contains only the steering of in_val/in_rdy and the dest extraction.

## Test plan
- Reset, then 1 cycle idle -> in_rdy = 1, both out_val = 0, num_free_d1 = num_free_d2 = 4.
- Enqueue msg dest=3 into domain 0; hold out_rdy_d1 = 0 -> next cycle out_val_d1 = 1, dest_d1 = 3, out_val_d2 = 0, num_free_d1 = 3.
- Fill domain 1 with 4 messages, out_rdy_d2 = 0 -> in_rdy = 0 when in_domain = 1. Switch to in_domain = 0 -> in_rdy = 1, and the enqueue lands in d1.
- Full d1 with out_rdy_d1 = 1 and in_val for domain 0 every cycle for 12 cycles:
  - enqueue refused on full cycles;
  - messages exit in FIFO order with dest sequence 0..7 and wrap, with no loss or duplication;
  - count never exceeds 4.
- Enqueue 3 messages to d2, then pulse reset for half a cycle between edges -> out_val_d2 = 0 immediately, num_free_d2 = 4. The next enqueue appears as the head.
- With PLAB4_NET_INBUF_BYPASS_EN, empty d1, in_val = 1, in_domain = 0, out_rdy_d1 = 1 -> out_val_d1 = 1 in the same cycle and count stays 0. Without the macro, out_val_d1 = 0 in that cycle and 1 in the next.
